// File: rtl/kuz_pkg.sv
// Shared types and constants for the Kuznyechik input packer and its assembler.
// Build option KUZ_PACKER_KEY_EN widens the assembler to hold a full 256-bit key.
package kuz_pkg;

  typedef logic [15:0][7:0] block_t;
  typedef logic [31:0][7:0] key_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LO,
    WAIT_HI
  } iss_state_t;

  localparam int BLK_WORDS = 4;
  localparam int KEY_WORDS = 8;

`ifdef KUZ_PACKER_KEY_EN
  localparam int ASM_W = 32 * KEY_WORDS;
`else
  localparam int ASM_W = 32 * BLK_WORDS;
`endif

endpackage

// File: rtl/kuz_word_asm.sv
// Word assembler: counts words of the current unit, latches its type/direction on
// word 0 and shifts words in so the first word ends up most significant.
module kuz_word_asm
  import kuz_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             accept_i,
  input  logic [31:0]      data_i,
  input  logic             key_i,
  input  logic             enc_i,
  output logic [2:0]       cnt_o,
  output logic             last_o,
  output logic             is_key_o,
  output logic             enc_o,
  output logic [ASM_W-1:0] unit_o,
  output logic             mismatch_o
);

  logic [2:0]       cnt_q, cnt_d;
  logic             type_q, type_d;
  logic             enc_q, enc_d;
  logic [ASM_W-33:0] sr_q, sr_d;

  // On word 0 nothing is latched yet, so the live inputs define the unit.
  assign is_key_o   = (cnt_q == 3'd0) ? key_i : type_q;
  assign enc_o      = (cnt_q == 3'd0) ? enc_i : enc_q;
  assign last_o     = is_key_o ? (cnt_q == 3'(KEY_WORDS - 1)) : (cnt_q == 3'(BLK_WORDS - 1));
  assign mismatch_o = accept_i && (cnt_q != 3'd0) && (key_i != type_q);
  assign unit_o     = {sr_q, data_i};
  assign cnt_o      = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    type_d = type_q;
    enc_d  = enc_q;
    sr_d   = sr_q;
    if (accept_i) begin
      sr_d  = unit_o[ASM_W-33:0];
      cnt_d = last_o ? 3'd0 : cnt_q + 3'd1;
      if (cnt_q == 3'd0) begin
        type_d = key_i;
        enc_d  = enc_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 3'd0;
      type_q <= 1'b0;
      enc_q  <= 1'b0;
      sr_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      type_q <= type_d;
      enc_q  <= enc_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/kuz_in_packer.sv
// Stream-to-core packer for the Kuznyechik core: one block slot, one key slot, issue FSM.
// Build option KUZ_PACKER_KEY_EN enables the key path; without it every unit is a block.
module kuz_in_packer
  import kuz_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_key,
  input  logic         s_enc,
  output logic         c_skey_valid,
  output logic [255:0] c_skey,
  output logic         c_valid,
  output logic [127:0] c_din,
  output logic         c_encrypt_decrypt_n,
  input  logic         c_ready,
  output logic         err,
  output logic         busy
);

  iss_state_t       state_q, state_d;
  logic [2:0]       asm_cnt;
  logic             asm_last, asm_is_key, asm_enc, asm_mismatch, asm_key_in;
  logic [ASM_W-1:0] asm_unit;
  logic             accept, fill_blk, iss_blk, iss_key, wd_expired;
  logic             blk_full_q, blk_enc_q;
  block_t           blk_q;
  logic             key_full, key_enc;
  logic             c_valid_q, c_enc_q, err_q;
  block_t           c_din_q;

`ifdef KUZ_PACKER_KEY_EN
  assign asm_key_in = s_key;
`else
  logic unused_s_key;
  assign unused_s_key = s_key;
  assign asm_key_in   = 1'b0;
`endif

  kuz_word_asm u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .accept_i   (accept),
    .data_i     (s_data),
    .key_i      (asm_key_in),
    .enc_i      (s_enc),
    .cnt_o      (asm_cnt),
    .last_o     (asm_last),
    .is_key_o   (asm_is_key),
    .enc_o      (asm_enc),
    .unit_o     (asm_unit),
    .mismatch_o (asm_mismatch)
  );

  // A slot issued this very cycle counts as free, so the completing unit lands in it.
  assign s_ready  = !(asm_last && ((blk_full_q && !iss_blk) || (asm_is_key && key_full && !iss_key)));
  assign accept   = s_valid && s_ready;
  assign fill_blk = accept && asm_last && !asm_is_key;

  always_comb begin
    state_d = state_q;
    iss_blk = 1'b0;
    iss_key = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_ready) begin
          if (blk_full_q) begin
            iss_blk = 1'b1;
            iss_key = key_full;
          end else if (key_full && (asm_cnt == 3'd0)) begin
            iss_key = 1'b1;
          end
          if (iss_blk || iss_key) state_d = WAIT_LO;
        end
      end
      WAIT_LO: if (!c_ready) state_d = WAIT_HI;
      WAIT_HI: if (c_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wd_expired) state_d = IDLE;
  end

  generate
    if (TIMEOUT_W > 0) begin : g_wd
      logic [TIMEOUT_W-1:0] wd_q, wd_d;
      assign wd_d       = (state_q == IDLE) ? '0 : wd_q + TIMEOUT_W'(1);
      assign wd_expired = (state_q != IDLE) && (&wd_q);
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) wd_q <= '0;
        else          wd_q <= wd_d;
      end
    end else begin : g_no_wd
      assign wd_expired = 1'b0;
    end
  endgenerate

`ifdef KUZ_PACKER_KEY_EN
  logic key_full_q, key_enc_q, fill_key, c_skey_valid_q;
  key_t key_q, c_skey_q;

  assign fill_key = accept && asm_last && asm_is_key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_full_q     <= 1'b0;
      key_enc_q      <= 1'b0;
      key_q          <= '0;
      c_skey_valid_q <= 1'b0;
      c_skey_q       <= '0;
    end else begin
      if (fill_key) begin
        key_full_q <= 1'b1;
        key_q      <= asm_unit;
        key_enc_q  <= asm_enc;
      end else if (iss_key) begin
        key_full_q <= 1'b0;
      end
      c_skey_valid_q <= iss_key;
      if (iss_key) c_skey_q <= key_q;
    end
  end

  assign key_full     = key_full_q;
  assign key_enc      = key_enc_q;
  assign c_skey_valid = c_skey_valid_q;
  assign c_skey       = c_skey_q;
`else
  assign key_full     = 1'b0;
  assign key_enc      = 1'b0;
  assign c_skey_valid = 1'b0;
  assign c_skey       = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      blk_full_q <= 1'b0;
      blk_enc_q  <= 1'b0;
      blk_q      <= '0;
      c_valid_q  <= 1'b0;
      c_din_q    <= '0;
      c_enc_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_blk) begin
        blk_full_q <= 1'b1;
        blk_q      <= asm_unit[32*BLK_WORDS-1:0];
        blk_enc_q  <= asm_enc;
      end else if (iss_blk) begin
        blk_full_q <= 1'b0;
      end
      c_valid_q <= iss_blk;
      if (iss_blk) c_din_q <= blk_q;
      // A joint issue takes the block's direction.
      if (iss_blk)      c_enc_q <= blk_enc_q;
      else if (iss_key) c_enc_q <= key_enc;
      err_q <= err_q | asm_mismatch | wd_expired;
    end
  end

  assign c_valid             = c_valid_q;
  assign c_din               = c_din_q;
  assign c_encrypt_decrypt_n = c_enc_q;
  assign err                 = err_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_kuz_in_packer.sv
// Randomised scoreboard bench for kuz_in_packer; expected issues are queued as units
// complete and a monitor compares every core pulse against the queue head.
`timescale 1ns/1ps
module tb_kuz_in_packer;
`ifdef KUZ_PACKER_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  localparam logic [255:0] KEY_VEC = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [127:0] BLK_VEC = 128'h1122334455667700ffeeddccbbaa9988;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, s_valid, s_ready, s_key, s_enc, c_skey_valid, c_valid, c_enc, c_ready, err, busy;
  logic [31:0] s_data;
  logic [255:0] c_skey;
  logic [127:0] c_din;

  logic w_valid, w_ready, w_key, w_enc_in, w_skv, w_v, w_enc, w_cready, w_err, w_busy;
  logic [31:0] w_data;
  logic [255:0] w_skey;
  logic [127:0] w_din;

  kuz_in_packer u_dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_key(s_key), .s_enc(s_enc), .c_skey_valid(c_skey_valid), .c_skey(c_skey),
    .c_valid(c_valid), .c_din(c_din), .c_encrypt_decrypt_n(c_enc), .c_ready(c_ready),
    .err(err), .busy(busy)
  );

  kuz_in_packer #(.TIMEOUT_W(4)) u_wd (
    .clk(clk), .reset_n(reset_n), .s_valid(w_valid), .s_ready(w_ready), .s_data(w_data),
    .s_key(w_key), .s_enc(w_enc_in), .c_skey_valid(w_skv), .c_skey(w_skey),
    .c_valid(w_v), .c_din(w_din), .c_encrypt_decrypt_n(w_enc), .c_ready(w_cready),
    .err(w_err), .busy(w_busy)
  );

  typedef struct packed {
    logic         kv;
    logic         v;
    logic [255:0] key;
    logic [127:0] din;
    logic         enc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int txn = 0;
  bit core_auto;
  int core_lat;
  logic [127:0] last_din;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic kv, input logic v, input logic [255:0] k,
                                  input logic [127:0] d, input logic e);
    exp_t x;
    x.kv = kv; x.v = v; x.key = k; x.din = d; x.enc = e;
    return x;
  endfunction

  // Monitor: every pulse to the core must match the oldest outstanding unit.
  always @(negedge clk) begin
    if (reset_n && (c_valid || c_skey_valid)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {c_skey_valid, c_valid}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: skey_valid=%0b valid=%0b din=%h enc=%0b", txn, c_skey_valid, c_valid, c_din, c_enc);
        chk("pulse_kv", c_skey_valid, e.kv);
        chk("pulse_v", c_valid, e.v);
        chk("pulse_enc", c_enc, e.enc);
        if (e.v) chk("pulse_din", c_din, e.din);
        if (e.kv) chk("pulse_skey", c_skey, e.key);
      end
    end
  end

  // Core model: drop ready after each pulse, hold low core_lat cycles, then raise.
  initial begin
    c_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (core_auto && reset_n && (c_valid || c_skey_valid)) begin
        c_ready = 1'b0;
        repeat (core_lat) @(negedge clk);
        c_ready = 1'b1;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic k, input logic e, output bit stalled);
    int waited;
    waited = 0;
    stalled = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_key = k; s_enc = e;
    forever begin
      #4;
      if (s_ready) begin
        @(posedge clk);
        break;
      end
      stalled = 1'b1;
      waited++;
      if (waited > 3000) begin
        chk("sready_timeout", s_ready, 1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_block(input logic [127:0] din, input logic e, input bit flip2,
                            input bit push, output bit last_stalled);
    bit st;
    logic kb, eb;
    st = 1'b0;
    for (int i = 0; i < 4; i++) begin
      kb = KEY_EN ? logic'(flip2 && (i == 2)) : 1'($urandom_range(0, 1));
      eb = (i == 0) ? e : 1'($urandom_range(0, 1));
      send_word(din[127-32*i -: 32], kb, eb, st);
    end
    last_stalled = st;
    if (push) begin
      exp_q.push_back(mk_exp(1'b0, 1'b1, '0, din, e));
      last_din = din;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

`ifdef KUZ_PACKER_KEY_EN
  task automatic send_key(input logic [255:0] k, input logic e, input bit push);
    bit st;
    for (int i = 0; i < 8; i++)
      send_word(k[255-32*i -: 32], 1'b1, (i == 0) ? e : 1'($urandom_range(0, 1)), st);
    if (push) exp_q.push_back(mk_exp(1'b1, 1'b0, k, '0, e));
    @(negedge clk);
    s_valid = 1'b0;
  endtask
`endif

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {exp_q.size() != 0, busy}, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_c_valid"}, c_valid, 0);
    chk({tag, "_c_skey_valid"}, c_skey_valid, 0);
    chk({tag, "_c_din"}, c_din, 0);
    chk({tag, "_c_skey"}, c_skey, 0);
    chk({tag, "_c_enc"}, c_enc, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bit st, st2, st3;
    int n;
    logic [127:0] rd;
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_key = 1'b0; s_enc = 1'b0;
    w_valid = 1'b0; w_data = '0; w_key = 1'b0; w_enc_in = 1'b0; w_cready = 1'b1;
    core_auto = 1'b1; core_lat = 3; last_din = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_rst");

    // Directed block with first-issue latency.
    send_block(BLK_VEC, 1'b1, 1'b0, 1'b1, st);
    chk("lat_early", c_valid, 0);
    @(negedge clk);
    chk("lat_pulse", c_valid, 1);
    chk("lat_busy", busy, 1);
    wait_drain();
    chk("err_clean", err, 0);

    // s_key toggles on word 2: error only when the key path exists; block still issues.
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b1, st);
    wait_drain();
    chk("err_mismatch", err, KEY_EN);

`ifdef KUZ_PACKER_KEY_EN
    send_key(KEY_VEC, 1'b0, 1'b1);
    wait_drain();
    core_auto = 1'b0;
    @(negedge clk);
    c_ready = 1'b0;
    send_key(KEY_VEC, 1'b0, 1'b0);
    send_block(BLK_VEC, 1'b1, 1'b0, 1'b0, st);
    exp_q.push_back(mk_exp(1'b1, 1'b1, KEY_VEC, BLK_VEC, 1'b1));
    last_din = BLK_VEC;
    c_ready = 1'b1;
    n = 0;
    while (!(c_valid || c_skey_valid) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("joint_pulse_seen", c_valid && c_skey_valid, 1);
    c_ready = 1'b0;
    repeat (2) @(negedge clk);
    c_ready = 1'b1;
    core_auto = 1'b1;
    wait_drain();
`endif

    // Random blocks with random gaps and core latencies.
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      core_lat = $urandom_range(1, 8);
      rd = {$urandom, $urandom, $urandom, $urandom};
      send_block(rd, 1'($urandom_range(0, 1)), 1'b0, 1'b1, st);
    end
    wait_drain();
    chk("din_hold", c_din, last_din);

    // Slow core: the third block's last word must stall.
    core_lat = 50;
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b1, st);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b1, st2);
    send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b1, st3);
    chk("no_early_drop", st2, 0);
    chk("sready_drop", st3, 1);
    wait_drain();
    core_lat = 3;

    // Reset while WAIT_HI with a partial unit, then a fresh block.
    core_auto = 1'b0;
    send_block(BLK_VEC, 1'b0, 1'b0, 1'b1, st);
    @(negedge clk);
    c_ready = 1'b0;
    send_word(32'hdeadbeef, 1'b0, 1'b1, st);
    send_word(32'hcafef00d, 1'b0, 1'b1, st);
    @(negedge clk);
    s_valid = 1'b0;
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    c_ready = 1'b1;
    reset_n = 1'b1;
    core_auto = 1'b1;
    send_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1, 1'b0, 1'b1, st);
    wait_drain();

    // Watchdog on the TIMEOUT_W=4 instance whose core never drops ready.
    @(negedge clk);
    w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = BLK_VEC[127-32*i -: 32];
      @(negedge clk);
    end
    w_valid = 1'b0;
    @(negedge clk);
    chk("wd_pulse", w_v, 1);
    chk("wd_din", w_din, BLK_VEC);
    repeat (10) @(negedge clk);
    chk("wd_err_early", w_err, 0);
    chk("wd_busy_early", w_busy, 1);
    n = 0;
    while (!w_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wd_err", w_err, 1);
    chk("wd_busy_after", w_busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    chk("err_final", err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kuz_in_packer.md
# kuz_in_packer

Upstream feeder for the f1_kuznyechik cipher core. Accepts a 32-bit word stream carrying 256-bit secret keys and 128-bit data blocks, and assembles complete keys and blocks. Issues them to the core as single-cycle skey_valid_s / valid_s pulses, then holds off until the core signals completion on ready. Provides one block slot and one key slot of buffering, so the next unit can be assembled while the core is busy.

## Interface
Parameters:
- TIMEOUT_W, default 8: width of the core-busy watchdog counter; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid && s_ready.
- s_data  in  32  stream word; first word of a unit is most significant.
- s_key  in  1  sampled on the first word of a unit: 1 = key unit (8 words), 0 = block unit (4 words).
- s_enc  in  1  sampled on the first word of a unit: encrypt_decrypt_n for that unit.
- c_skey_valid  out  1  drives core skey_valid_s.
- c_skey  out  256  drives core skey.
- c_valid  out  1  drives core valid_s.
- c_din  out  128  drives core din.
- c_encrypt_decrypt_n  out  1  drives core encrypt_decrypt_n.
- c_ready  in  1  core ready (high = idle/done).
- err  out  1  sticky protocol error.
- busy  out  1  high while a core transaction is outstanding.

## Operation
- Assembler:
  - 3-bit word counter; unit type and direction are latched on word 0.
  - s_key on later words is ignored for typing. A mismatch sets err; the word is still counted.
  - Block unit: word i fills c_din[127-32i -: 32]. Key unit: word i fills c_skey[255-32i -: 32].
- Slot fill on the last word:
  - Block goes to the block slot.
  - Key goes to the key slot.
- s_ready = 0 while the current word is the last of its unit and any of these holds:
  - target slot is full;
  - unit is a key and the block slot is full (preserves ordering).
- Issue FSM states: IDLE, WAIT_LO, WAIT_HI.
- IDLE, with c_ready = 1, issues a one-cycle pulse:
  - Key and block slots both full: c_skey_valid = c_valid = 1 in the same cycle; direction is the block's.
  - Block slot only: c_valid = 1.
  - Key slot only, block slot empty, assembler counter 0: c_skey_valid = 1; direction is the key's.
  - The issued slots clear, and the FSM goes to WAIT_LO.
- WAIT_LO: stay until c_ready = 0, then go to WAIT_HI.
- WAIT_HI: stay until c_ready = 1, then go to IDLE.
- busy = (state != IDLE).
- Watchdog (TIMEOUT_W > 0):
  - Counter is cleared in IDLE and increments in WAIT_LO/WAIT_HI.
  - On all-ones it sets err and forces IDLE.
- c_din, c_skey and c_encrypt_decrypt_n hold their last issued values between pulses.

## Timing
- Reset values: s_ready = 1, c_valid = c_skey_valid = 0, c_din = 0, c_skey = 0, c_encrypt_decrypt_n = 0, err = 0, busy = 0, state IDLE, slots empty, counter 0.
- Latency: last word accepted at edge k → slot full after k → pulse high for cycle after edge k+1 (if IDLE and c_ready = 1).
- Issue and slot fill in the same edge: fill wins for the emptied slot (no lost unit).
- A slot fills during WAIT_*: its pulse issues on the first IDLE cycle with c_ready = 1.
- Reset mid-transaction: everything returns to reset values immediately; the outstanding core operation is abandoned and the partial unit is discarded.

## Configuration
- KUZ_PACKER_KEY_EN defined: key path present as above.
- Undefined:
  - s_key is ignored and every unit is a 4-word block.
  - Key slot and its registers are removed.
  - c_skey_valid is tied 0 and c_skey is tied 0.
  - The core must be keyed by other means.

## Structure
- Shared package kuz_pkg holds:
  - block_t = logic [15:0][7:0];
  - key_t = logic [31:0][7:0];
  - state enum iss_state_t {IDLE, WAIT_LO, WAIT_HI};
  - localparams BLK_WORDS = 4, KEY_WORDS = 8.
- One sub-module, kuz_word_asm: word counter, type/direction latch, shift-in register, err-on-mismatch. The parent owns the slots, the FSM and the watchdog.

## Test plan
- Key words 8899aabb, ccddeeff, 00112233, 44556677, fedcba98, 76543210, 01234567, 89abcdef (s_key = 1, s_enc = 0), c_ready = 1 → one c_skey_valid pulse with c_skey = 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, c_encrypt_decrypt_n = 0, c_valid = 0.
- Same key, then block 11223344, 55667700, ffeeddcc, bbaa9988 (s_enc = 1) streamed back-to-back before issue → single cycle with c_skey_valid = c_valid = 1, c_din = 1122334455667700ffeeddccbbaa9988. With the real core attached, the core's dout is 7f679d90bebc24305a468d42b9d4edcd.
- Three blocks streamed while the model holds c_ready low for 50 cycles → s_ready drops on the last word of block 3. Blocks are issued in order, one per core ready rise.
- c_ready never falls after issue, TIMEOUT_W = 4 → err = 1 after 15 cycles, FSM back to IDLE, busy = 0.
- s_key toggles on word 2 of a block → err = 1, block still issued after 4 words.
- reset_n asserted in WAIT_HI with a partial unit → all outputs at reset values. A fresh block after release issues normally.
